// File: rtl/cargador_instrucciones_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// widths of the header, the instruction word and the incoming byte.
package cargador_instrucciones_pkg;

   localparam int ANCHO_CABECERA = 16;
   localparam int ANCHO_PALABRA  = 32;
   localparam int ANCHO_BYTE     = 8;
   localparam int BYTES_PALABRA  = ANCHO_PALABRA / ANCHO_BYTE;

   typedef enum logic [2:0] {
      CAB_H,
      CAB_L,
      RECIBE,
      ESCRIBE,
      FIN,
      ERROR
   } estado_t;

endpackage

// File: rtl/cargador_instrucciones_timeout.sv
// Idle-cycle counter for the loader: counts enabled cycles, clears on demand
// and flags the cycle whose increment would reach TIMEOUT (0 disables it).
module contador_timeout #(
   parameter int TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic limpiar,
   input  logic habilitar,
   output logic vencido
);

   localparam int ANCHO = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ANCHO-1:0] ULTIMO = (TIMEOUT > 0) ? ANCHO'(TIMEOUT - 1) : '0;

   logic [ANCHO-1:0] cuenta;

   // Saturates at ULTIMO; the loader leaves the timed states on that cycle.
   always_ff @(posedge clk) begin
      if (reset || limpiar) begin
         cuenta <= '0;
      end else if (habilitar && (cuenta != ULTIMO)) begin
         cuenta <= cuenta + ANCHO'(1);
      end
   end

   assign vencido = (TIMEOUT != 0) && habilitar && !limpiar && (cuenta == ULTIMO);

endmodule

// File: rtl/cargador_instrucciones.sv
// Program loader: takes a word-count header and a byte stream, packs bytes
// MSB-first into 32-bit words and writes them to instruction memory from 0.
module cargador_instrucciones
   import cargador_instrucciones_pkg::*;
#(
   parameter int ANCHO_DIR = 10,
   parameter int TIMEOUT   = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            dato_in,
   input  logic                  dato_valido,
   output logic                  listo,
   output logic                  we_mem,
   output logic [ANCHO_DIR-1:0]  dir_mem,
   output logic [31:0]           dato_mem,
   output logic                  cpu_reset,
   output logic                  fin_carga,
   output logic                  error_carga
);

   localparam logic [31:0] MAX_PALABRAS = 32'd1 << ANCHO_DIR;

   estado_t                              estado;
   logic [ANCHO_BYTE-1:0]                cab_alta;
   logic [ANCHO_CABECERA-1:0]            n_palabras;
   logic [ANCHO_DIR:0]                   indice;
   logic [1:0]                           cuenta_bytes;
   logic [ANCHO_PALABRA-ANCHO_BYTE-1:0]  parcial;

   logic                       aceptar;
   logic [ANCHO_CABECERA-1:0]  n_recibido;
   logic                       cabecera_ok;
   logic                       ultima;
   logic                       en_espera;
   logic                       vencido;

   assign aceptar     = dato_valido && listo;
   assign n_recibido  = {cab_alta, dato_in};
   assign cabecera_ok = (n_recibido != '0) && (32'(n_recibido) <= MAX_PALABRAS);
   // The index is one bit wider than the address so N = 2^ANCHO_DIR never wraps.
   assign ultima      = ((32'(indice) + 32'd1) == 32'(n_palabras));
   assign en_espera   = ((estado == CAB_L) || (estado == RECIBE)) && !aceptar;

   contador_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .limpiar   (aceptar),
      .habilitar (en_espera),
      .vencido   (vencido)
   );

   // Single FSM; every output is registered and set for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado       <= CAB_H;
         cab_alta     <= '0;
         n_palabras   <= '0;
         indice       <= '0;
         cuenta_bytes <= '0;
         parcial      <= '0;
         listo        <= 1'b0;
         we_mem       <= 1'b0;
         dir_mem      <= '0;
         dato_mem     <= '0;
         cpu_reset    <= 1'b1;
         fin_carga    <= 1'b0;
         error_carga  <= 1'b0;
      end else begin
         case (estado)
            CAB_H: begin
               listo <= 1'b1;
               if (aceptar) begin
                  cab_alta <= dato_in;
                  estado   <= CAB_L;
               end
            end

            CAB_L: begin
               if (aceptar) begin
                  n_palabras <= n_recibido;
                  if (cabecera_ok) begin
                     estado <= RECIBE;
                  end else begin
                     estado      <= ERROR;
                     listo       <= 1'b0;
                     error_carga <= 1'b1;
                  end
               end else if (vencido) begin
                  estado      <= ERROR;
                  listo       <= 1'b0;
                  error_carga <= 1'b1;
               end
            end

            RECIBE: begin
               if (aceptar) begin
                  parcial      <= {parcial[ANCHO_PALABRA-2*ANCHO_BYTE-1:0], dato_in};
                  cuenta_bytes <= cuenta_bytes + 2'd1;
                  if (cuenta_bytes == 2'(BYTES_PALABRA - 1)) begin
                     estado   <= ESCRIBE;
                     listo    <= 1'b0;
                     we_mem   <= 1'b1;
                     dato_mem <= {parcial, dato_in};
                     dir_mem  <= indice[ANCHO_DIR-1:0];
                  end
               end else if (vencido) begin
                  estado      <= ERROR;
                  listo       <= 1'b0;
                  error_carga <= 1'b1;
               end
            end

            ESCRIBE: begin
               we_mem <= 1'b0;
               indice <= indice + 1'b1;
               if (ultima) begin
                  estado    <= FIN;
                  cpu_reset <= 1'b0;
                  fin_carga <= 1'b1;
               end else begin
                  estado <= RECIBE;
                  listo  <= 1'b1;
               end
            end

            FIN: begin
               listo     <= 1'b0;
               cpu_reset <= 1'b0;
               fin_carga <= 1'b1;
            end

            ERROR: begin
               listo       <= 1'b0;
               error_carga <= 1'b1;
            end

            default: begin
               estado <= CAB_H;
               listo  <= 1'b0;
               we_mem <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Self-checking bench for the program loader: header table, random programs
// compared against a byte-list memory model, plus timeout/reset/depth cases.
module tb_cargador_instrucciones;

   localparam int ANCHO_DIR = 10;
   localparam int TIMEOUT   = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [7:0]            dato_in;
   logic                  dato_valido;
   logic                  listo;
   logic                  we_mem;
   logic [ANCHO_DIR-1:0]  dir_mem;
   logic [31:0]           dato_mem;
   logic                  cpu_reset;
   logic                  fin_carga;
   logic                  error_carga;

   typedef struct {
      logic [ANCHO_DIR-1:0] dir;
      logic [31:0]          dato;
   } escritura_t;

   typedef struct {
      logic [7:0] hi;
      logic [7:0] lo;
      int         palabras;
      int         hueco_max;
      bit         exp_err;
      bit         exp_fin;
   } vector_t;

   escritura_t capturas[$];
   logic [7:0] programa[$];
   vector_t    vectores[7];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   cargador_instrucciones #(
      .ANCHO_DIR (ANCHO_DIR),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .dato_in     (dato_in),
      .dato_valido (dato_valido),
      .listo       (listo),
      .we_mem      (we_mem),
      .dir_mem     (dir_mem),
      .dato_mem    (dato_mem),
      .cpu_reset   (cpu_reset),
      .fin_carga   (fin_carga),
      .error_carga (error_carga)
   );

   // Memory-side monitor: records every write and checks the loader is busy then.
   always @(negedge clk) begin
      if (we_mem === 1'b1) begin
         capturas.push_back('{dir: dir_mem, dato: dato_mem});
         checks++;
         if (listo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL listo_en_escritura: actual=%0b expected=0 at %0t", listo, $time);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", nombre, actual, esperado);
      end
   endtask

   // Offers one byte after an idle gap and holds it until the loader takes it.
   task automatic applyStimulus(input logic [7:0] b, input int hueco);
      bit tomado = 1'b0;
      dato_valido = 1'b0;
      repeat (hueco) begin
         @(posedge clk);
         #1;
      end
      dato_in     = b;
      dato_valido = 1'b1;
      for (int c = 0; c < 100 && !tomado; c++) begin
         logic l;
         @(negedge clk);
         l = listo;
         @(posedge clk);
         #1;
         tomado = l;
      end
      dato_valido = 1'b0;
      if (!tomado) checkOutput("handshake_aceptado", 32'd0, 32'd1);
   endtask

   task automatic hacer_reset();
      reset       = 1'b1;
      dato_valido = 1'b0;
      dato_in     = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      capturas.delete();
   endtask

   task automatic enviar_carga(input logic [7:0] hi, input logic [7:0] lo, input int hueco_max);
      applyStimulus(hi, $urandom_range(hueco_max, 0));
      applyStimulus(lo, $urandom_range(hueco_max, 0));
      foreach (programa[i]) applyStimulus(programa[i], $urandom_range(hueco_max, 0));
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Reference: word i is bytes 4i..4i+3 of the program, high byte first, at address i.
   task automatic verificar(input string caso, input int n_pal, input bit exp_err, input bit exp_fin);
      int esperadas = exp_err ? 0 : n_pal;
      checkOutput({caso, ".error_carga"}, 32'(error_carga), 32'(exp_err));
      checkOutput({caso, ".fin_carga"}, 32'(fin_carga), 32'(exp_fin));
      checkOutput({caso, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_fin));
      checkOutput({caso, ".listo"}, 32'(listo), 32'd0);
      checkOutput({caso, ".num_escrituras"}, 32'(capturas.size()), 32'(esperadas));
      for (int i = 0; i < esperadas && i < capturas.size(); i++) begin
         logic [31:0] palabra = {programa[4*i], programa[4*i+1], programa[4*i+2], programa[4*i+3]};
         checkOutput($sformatf("%s.dir[%0d]", caso, i), 32'(capturas[i].dir), 32'(i));
         checkOutput($sformatf("%s.dato[%0d]", caso, i), capturas[i].dato, palabra);
      end
   endtask

   initial begin
      reset       = 1'b1;
      dato_valido = 1'b0;
      dato_in     = 8'h00;

      vectores[0] = '{8'h00, 8'h00, 0, 4, 1'b1, 1'b0};
      vectores[1] = '{8'h04, 8'h01, 0, 4, 1'b1, 1'b0};
      vectores[2] = '{8'hFF, 8'hFF, 0, 2, 1'b1, 1'b0};
      vectores[3] = '{8'h00, 8'h01, 1, 4, 1'b0, 1'b1};
      vectores[4] = '{8'h00, 8'h03, 3, 0, 1'b0, 1'b1};
      vectores[5] = '{8'h00, 8'h06, 6, 4, 1'b0, 1'b1};
      vectores[6] = '{8'h01, 8'h00, 256, 1, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset.listo", 32'(listo), 32'd0);
      checkOutput("reset.we_mem", 32'(we_mem), 32'd0);
      checkOutput("reset.dir_mem", 32'(dir_mem), 32'd0);
      checkOutput("reset.dato_mem", dato_mem, 32'd0);
      checkOutput("reset.cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("reset.fin_carga", 32'(fin_carga), 32'd0);
      checkOutput("reset.error_carga", 32'(error_carga), 32'd0);

      $display("[TB] nominal two-word load");
      hacer_reset();
      programa = '{8'h00, 8'h21, 8'h48, 8'h20, 8'h01, 8'h29, 8'h48, 8'h20};
      enviar_carga(8'h00, 8'h02, 0);
      verificar("nominal", 2, 1'b0, 1'b1);
      checkOutput("nominal.palabra0", capturas.size() > 0 ? capturas[0].dato : 32'hX, 32'h0021_4820);
      checkOutput("nominal.palabra1", capturas.size() > 1 ? capturas[1].dato : 32'hX, 32'h0129_4820);
      dato_in     = 8'h55;
      dato_valido = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      dato_valido = 1'b0;
      checkOutput("nominal.sin_mas_escrituras", 32'(capturas.size()), 32'd2);
      checkOutput("nominal.fin_sostenido", 32'(fin_carga), 32'd1);

      $display("[TB] header and random-program table");
      for (int v = 0; v < 7; v++) begin
         hacer_reset();
         programa.delete();
         for (int i = 0; i < 4 * vectores[v].palabras; i++) programa.push_back(8'($urandom));
         enviar_carga(vectores[v].hi, vectores[v].lo, vectores[v].hueco_max);
         verificar($sformatf("vector%0d", v), vectores[v].palabras, vectores[v].exp_err, vectores[v].exp_fin);
      end

      $display("[TB] timeout after header and two bytes");
      hacer_reset();
      applyStimulus(8'h00, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h5A, 0);
      repeat (TIMEOUT - 1) @(posedge clk);
      @(negedge clk);
      checkOutput("timeout.aun_no", 32'(error_carga), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("timeout.error_carga", 32'(error_carga), 32'd1);
      checkOutput("timeout.cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("timeout.listo", 32'(listo), 32'd0);
      checkOutput("timeout.sin_escrituras", 32'(capturas.size()), 32'd0);

      $display("[TB] reset in the middle of a word");
      hacer_reset();
      applyStimulus(8'h00, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h11, 0);
      applyStimulus(8'h22, 1);
      applyStimulus(8'h33, 0);
      reset       = 1'b1;
      dato_in     = 8'h77;
      dato_valido = 1'b1;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      dato_valido = 1'b0;
      @(negedge clk);
      checkOutput("reset_medio.cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("reset_medio.fin_carga", 32'(fin_carga), 32'd0);
      programa = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      enviar_carga(8'h00, 8'h01, 0);
      verificar("reset_medio", 1, 1'b0, 1'b1);
      checkOutput("reset_medio.palabra", capturas.size() > 0 ? capturas[0].dato : 32'hX, 32'hDEAD_BEEF);

      $display("[TB] full-depth load of 1024 words");
      hacer_reset();
      programa.delete();
      for (int i = 0; i < 4096; i++) programa.push_back(8'(i));
      enviar_carga(8'h04, 8'h00, 0);
      verificar("profundidad", 1024, 1'b0, 1'b1);
      checkOutput("profundidad.ultima_dir", capturas.size() > 0 ? 32'(capturas[capturas.size()-1].dir) : 32'hX, 32'd1023);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cargador_instrucciones.md
Name: cargador_instrucciones

Overview:
- Program loader: the write side of the instruction memory. Receives a byte stream over a valid/ready handshake, assembles 32-bit instruction words MSB-first and writes them sequentially into instruction memory from address 0.
- Holds the pipeline in reset until the whole program is written, then releases it.
- Sits between the host/serial front-end and the instruction memory's write port.

Parameters:
- ANCHO_DIR, 10, instruction memory address width (1024 words)
- TIMEOUT, 1000000, max idle cycles between bytes once a load has started; 0 disables the timeout

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- dato_in  input  8  incoming byte
- dato_valido  input  1  dato_in valid this cycle
- listo  output  1  loader can accept a byte this cycle
- we_mem  output  1  instruction memory write enable, one-cycle pulse per word
- dir_mem  output  ANCHO_DIR  write address
- dato_mem  output  32  write data
- cpu_reset  output  1  holds the pipeline in reset while high
- fin_carga  output  1  program fully loaded (sticky)
- error_carga  output  1  bad header or timeout (sticky)

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: listo=0, we_mem=0, dir_mem=0, dato_mem=0, cpu_reset=1, fin_carga=0, error_carga=0. State=CAB_H, byte counter=0, word counter=0, timeout counter=0.
- Handshake: a byte is accepted on a rising edge where dato_valido=1 and listo=1. dato_valido while listo=0 is ignored and the byte is dropped; the sender must hold it.
- listo is registered. It is 1 in CAB_H, CAB_L and RECIBE, and 0 in ESCRIBE, FIN and ERROR.
- Header: 16-bit word count N, high byte first.
  - CAB_H: accept byte -> store N[15:8] -> CAB_L.
  - CAB_L: accept byte -> form N. If 1 <= N <= 2^ANCHO_DIR, go to RECIBE. Otherwise go to ERROR.
- RECIBE: each accepted byte shifts into a 32-bit assembly register, MSB first. The first byte becomes bits [31:24].
  - On acceptance of the 4th byte, go to ESCRIBE.
  - The next cycle has we_mem=1, dato_mem=assembled word, dir_mem=current word index.
- ESCRIBE (exactly 1 cycle): we_mem high for this cycle only; the write commits at the rising edge that ends the cycle.
  - Then increment the word index.
  - If the written word was word N-1, go to FIN. Otherwise go to RECIBE.
- Latency: 4th byte accepted at edge k -> we_mem high during cycle k+1 -> listo high again at cycle k+2.
- FIN: cpu_reset=0 and fin_carga=1 from the first FIN cycle. Bytes are ignored. The state holds until reset.
- ERROR: error_carga=1 and cpu_reset stays 1. The state holds until reset.
- dir_mem/dato_mem hold their last values when we_mem=0.
- Timeout: counting starts once the first header byte has been accepted.
  - The counter increments every cycle in CAB_L/RECIBE without an accepted byte, and clears on every accepted byte.
  - When the counter reaches TIMEOUT, go to ERROR.
  - Timeout is inactive in CAB_H, FIN and ERROR.
- N=1024 with ANCHO_DIR=10: the last write goes to address 1023 and the word index must not wrap before FIN. Use an ANCHO_DIR+1-bit counter.
- Reset mid-load: the partially assembled word is discarded and no write is issued. The loader restarts at CAB_H with cpu_reset=1. Words already written stay in memory; the loader does not clear them.
- Simultaneous reset and dato_valido: reset wins and the byte is not accepted.

Decomposition:
- Shared package/include: state encodings (CAB_H, CAB_L, RECIBE, ESCRIBE, FIN, ERROR), header width (16), word width (32), byte width (8).
- One sub-module: contador_timeout (cycle counter with clear, enable and terminal-count flag, width from TIMEOUT). Everything else stays in the top FSM.

Test Plan:
- Nominal load: header 0x00,0x02; bytes 00 21 48 20 01 29 48 20 -> we_mem pulses with (dir=0, 0x00214820) then (dir=1, 0x01294820). Then fin_carga=1 and cpu_reset=0; no further we_mem.
- Bad header: header 0x00,0x00 -> error_carga=1, cpu_reset=1, listo=0, no writes. Header 0x04,0x01 (1025) -> same response.
- Backpressure: hold dato_valido=1 continuously across word boundaries -> exactly 4 bytes accepted per word. listo=0 during each ESCRIBE cycle, and no byte is lost or duplicated (checked by scoreboard).
- Timeout: TIMEOUT=16; send header 0x00,0x01 and 2 bytes, then go idle -> error_carga asserts on the 16th idle cycle, and no we_mem occurs.
- Reset mid-word: N=1, send 3 bytes, pulse reset one cycle, then send a full header plus word 0xDEADBEEF -> single write (dir=0, 0xDEADBEEF); no write with the partial data.
- Full depth: N=1024 with incrementing data -> 1024 writes at addresses 0..1023 and fin_carga after the write to address 1023; dir_mem never wraps to 0 with we_mem=1.
